// File: rtl/intel_vip_reset_sequencer.sv
// Multi-channel reset synchroniser and sequencer: synchronises reset_in,
// stretches it, then releases each channel in index order with a gap.
module intel_vip_reset_sequencer #(
    parameter int NUM_OUTPUTS            = 4,
    parameter int SYNC_DEPTH             = 3,
    parameter int ADDITIONAL_DEPTH       = 2,
    parameter int MIN_ASSERT_CYCLES      = 16,
    parameter int RELEASE_GAP_CYCLES     = 8,
    parameter int DISABLE_GLOBAL_NETWORK = 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   sw_reset_req,
    input  logic [NUM_OUTPUTS-1:0] hold_in,
    output logic                   clk_out,
    output logic [NUM_OUTPUTS-1:0] reset_out,
    output logic                   reset_done
);

    localparam int MAXC = (MIN_ASSERT_CYCLES > RELEASE_GAP_CYCLES) ?
                          MIN_ASSERT_CYCLES : RELEASE_GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [CW-1:0] MIN_M1 = CW'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(RELEASE_GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST   = IW'(NUM_OUTPUTS - 1);

    localparam GN_ATTR = (DISABLE_GLOBAL_NETWORK != 0) ?
                         "-name GLOBAL_SIGNAL OFF" : "";

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_e;

    (* preserve *) logic [SYNC_DEPTH-1:0] sync_q;

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [IW-1:0]            idx_q;
    logic [NUM_OUTPUTS-1:0]   chan_q;

    (* altera_attribute = GN_ATTR *)
    logic [ADDITIONAL_DEPTH-1:0][NUM_OUTPUTS-1:0] pipe_q;
    (* altera_attribute = GN_ATTR *)
    logic [ADDITIONAL_DEPTH-1:0]                  done_pipe_q;

    logic sync_rst;
    logic due;
    logic held;

    assign clk_out  = clk_in;
    assign sync_rst = sync_q[SYNC_DEPTH-1];
    assign held     = hold_in[idx_q];

    // Counter restarts at each release, so equality marks the scheduled edge.
    assign due = ((state_q == ST_HOLD)    && (cnt_q == MIN_M1)) ||
                 ((state_q == ST_RELEASE) && (cnt_q == GAP_M1));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '1;
        end else if (sync_rst || sw_reset_req) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '1;
        end else begin
            unique case (state_q)
                ST_HOLD, ST_RELEASE: begin
                    if (due && !held) begin
                        chan_q[idx_q] <= 1'b0;
                        cnt_q         <= '0;
                        if (idx_q == LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else if (due) begin
                        // Park on the due count until the hold drops.
                        state_q <= ST_RELEASE;
                        cnt_q   <= GAP_M1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pipe_q      <= '1;
            done_pipe_q <= '0;
        end else begin
            pipe_q      <= {pipe_q[ADDITIONAL_DEPTH-2:0], chan_q};
            done_pipe_q <= {done_pipe_q[ADDITIONAL_DEPTH-2:0],
                            (state_q == ST_DONE)};
        end
    end

    assign reset_out  = pipe_q[ADDITIONAL_DEPTH-1];
    assign reset_done = done_pipe_q[ADDITIONAL_DEPTH-1];

endmodule

// File: tb/tb_intel_vip_reset_sequencer.sv
// Directed bench for intel_vip_reset_sequencer: default instance plus a
// minimal single-channel instance.
module tb_intel_vip_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic [3:0] hold;
    logic       co;
    logic [3:0] out;
    logic       done;

    logic       sw6;
    logic [0:0] hold6;
    logic       co6;
    logic [0:0] out6;
    logic       done6;

    int n_chk  = 0;
    int n_fail = 0;
    int ecnt   = 0;

    always #5 clk = ~clk;

    intel_vip_reset_sequencer u_dut (
        .clk_in       (clk),
        .reset_in     (rst),
        .sw_reset_req (sw),
        .hold_in      (hold),
        .clk_out      (co),
        .reset_out    (out),
        .reset_done   (done)
    );

    intel_vip_reset_sequencer #(
        .NUM_OUTPUTS        (1),
        .SYNC_DEPTH         (2),
        .ADDITIONAL_DEPTH   (2),
        .MIN_ASSERT_CYCLES  (1),
        .RELEASE_GAP_CYCLES (1)
    ) u_min (
        .clk_in       (clk),
        .reset_in     (rst),
        .sw_reset_req (sw6),
        .hold_in      (hold6),
        .clk_out      (co6),
        .reset_out    (out6),
        .reset_done   (done6)
    );

    typedef struct {
        int         ed;
        logic [4:0] exp;
        logic [1:0] exp6;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [4:0] got,
                       input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b expected %b",
                     nm, ecnt, got, exp);
        end
    endtask

    task automatic goto(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            ecnt++;
            #1;
        end
    endtask

    task automatic power_on();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst", {done, out}, 5'b01111);
        chk("async_rst6", {3'b000, done6, out6}, 5'b00001);
        #2;
        rst  = 1'b0;
        ecnt = 0;
    endtask

    initial begin
        rst   = 1'b1;
        sw    = 1'b0;
        hold  = 4'b0000;
        sw6   = 1'b0;
        hold6 = 1'b0;

        tv[0]  = '{0,  5'b01111, 2'b01};
        tv[1]  = '{4,  5'b01111, 2'b01};
        tv[2]  = '{5,  5'b01111, 2'b10};
        tv[3]  = '{20, 5'b01111, 2'b10};
        tv[4]  = '{21, 5'b01110, 2'b10};
        tv[5]  = '{28, 5'b01110, 2'b10};
        tv[6]  = '{29, 5'b01100, 2'b10};
        tv[7]  = '{36, 5'b01100, 2'b10};
        tv[8]  = '{37, 5'b01000, 2'b10};
        tv[9]  = '{44, 5'b01000, 2'b10};
        tv[10] = '{45, 5'b10000, 2'b10};
        tv[11] = '{60, 5'b10000, 2'b10};
        tv[12] = '{90, 5'b10000, 2'b10};

        repeat (2) @(posedge clk);

        // Power-on with both instances, no holds
        power_on();
        for (int i = 0; i < 13; i++) begin
            goto(tv[i].ed);
            chk("pwr_on", {done, out}, tv[i].exp);
            chk("min_cfg", {3'b000, done6, out6}, {3'b000, tv[i].exp6});
        end
        chk("clk_out", {4'b0000, co}, {4'b0000, clk});
        chk("clk_out6", {4'b0000, co6}, {4'b0000, clk});

        // Hold on ch1 delays it; hold on ch3 before it is next is ignored
        hold = 4'b1010;
        power_on();
        goto(40);
        chk("hold_ch1_40", {done, out}, 5'b01110);
        hold = 4'b1000;
        goto(42);
        chk("hold_ch1_42", {done, out}, 5'b01110);
        goto(43);
        chk("hold_ch1_43", {done, out}, 5'b01100);
        goto(45);
        hold = 4'b0000;
        goto(50);
        chk("hold_ch2_50", {done, out}, 5'b01100);
        goto(51);
        chk("hold_ch2_51", {done, out}, 5'b01000);
        goto(58);
        chk("hold_ch3_58", {done, out}, 5'b01000);
        goto(59);
        chk("hold_ch3_59", {done, out}, 5'b10000);
        hold = 4'b1111;
        goto(70);
        chk("done_ign_hold", {done, out}, 5'b10000);
        hold = 4'b0000;

        // Software reset pulse in DONE, then held high for several edges
        power_on();
        goto(99);
        sw = 1'b1;
        goto(100);
        sw = 1'b0;
        goto(101);
        chk("sw_101", {done, out}, 5'b10000);
        goto(102);
        chk("sw_102", {done, out}, 5'b01111);
        goto(117);
        chk("sw_117", {done, out}, 5'b01111);
        goto(118);
        chk("sw_118", {done, out}, 5'b01110);
        goto(129);
        sw = 1'b1;
        goto(134);
        sw = 1'b0;
        goto(151);
        chk("swlvl_151", {done, out}, 5'b01111);
        goto(152);
        chk("swlvl_152", {done, out}, 5'b01110);

        // Async reset pulse mid-release, no clock edge during the pulse
        power_on();
        goto(30);
        chk("mid_30", {done, out}, 5'b01100);
        rst = 1'b1;
        #1;
        chk("mid_async", {done, out}, 5'b01111);
        #1;
        rst  = 1'b0;
        ecnt = 0;
        goto(20);
        chk("re_20", {done, out}, 5'b01111);
        goto(21);
        chk("re_21", {done, out}, 5'b01110);
        goto(45);
        chk("re_45", {done, out}, 5'b10000);

        // Request on ch2's scheduled release edge wins
        power_on();
        goto(34);
        sw = 1'b1;
        goto(35);
        sw = 1'b0;
        chk("coinc_35", {done, out}, 5'b01100);
        goto(37);
        chk("coinc_37", {done, out}, 5'b01111);
        goto(52);
        chk("coinc_52", {done, out}, 5'b01111);
        goto(53);
        chk("coinc_53", {done, out}, 5'b01110);

        // Request while the synchroniser still asserts is ignored
        sw = 1'b1;
        power_on();
        goto(3);
        sw = 1'b0;
        goto(20);
        chk("sync_sw_20", {done, out}, 5'b01111);
        goto(21);
        chk("sync_sw_21", {done, out}, 5'b01110);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
